// File: rtl/chip_tester_pkg.sv
// +--------------------------------------------------------------------------+
// | chip_tester_pkg : shared types and gate truth function for chip testers   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package chip_tester_pkg;

  typedef enum logic [2:0] {
    MODE_NAND  = 3'd0,
    MODE_NOR   = 3'd1,
    MODE_AND   = 3'd2,
    MODE_OR    = 3'd3,
    MODE_XOR   = 3'd4,
    MODE_XNOR  = 3'd5,
    MODE_RSVD6 = 3'd6,
    MODE_RSVD7 = 3'd7
  } gate_mode_t;

  typedef enum logic [2:0] {
    ST_HALTED = 3'd0,
    ST_SET    = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } tester_state_t;

  function automatic logic gate_expect(gate_mode_t mode, logic a, logic b);
    logic y;
    case (mode)
      MODE_NAND: y = ~(a & b);
      MODE_NOR:  y = ~(a | b);
      MODE_AND:  y = a & b;
      MODE_OR:   y = a | b;
      MODE_XOR:  y = a ^ b;
      MODE_XNOR: y = ~(a ^ b);
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

  function automatic logic mode_valid(gate_mode_t mode);
    return (mode <= MODE_XNOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bus.sv
// +--------------------------------------------------------------------------+
// | sync_bus : per-bit flop chain bringing asynchronous socket outputs in     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gate_array_checker.sv
// +--------------------------------------------------------------------------+
// | gate_array_checker : exercises every 2-input gate of a 74xx quad/hex chip |
// | with all four A/B vectors and reports pass/fail, fail mask, first vector  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module gate_array_checker
  import chip_tester_pkg::*;
#(
  parameter int N_GATES       = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Run,
  input  logic               DISP_RSLT,
  input  logic [2:0]         Mode,
  output logic [N_GATES-1:0] GateA,
  output logic [N_GATES-1:0] GateB,
  input  logic [N_GATES-1:0] GateY,
  output logic               Done,
  output logic               RSLT,
  output logic [N_GATES-1:0] FailMask,
  output logic [1:0]         FailVec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < SYNC_STAGES) begin : g_param_check
      $error("gate_array_checker: SETTLE_CYCLES must be >= SYNC_STAGES");
    end
  endgenerate

  tester_state_t        state_q, state_d;
  gate_mode_t           mode_q, mode_d;
  logic [1:0]           vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_GATES-1:0]   gate_a_q, gate_a_d;
  logic [N_GATES-1:0]   gate_b_q, gate_b_d;
  logic                 done_q, done_d;
  logic                 rslt_q, rslt_d;
  logic [N_GATES-1:0]   fail_mask_q, fail_mask_d;
  logic [1:0]           fail_vec_q, fail_vec_d;
  logic                 first_fail_q, first_fail_d;
  logic [N_GATES-1:0]   sync_y;
  logic [N_GATES-1:0]   exp_y;
  logic [N_GATES-1:0]   mism;
  gate_mode_t           mode_in;

  assign mode_in = gate_mode_t'(Mode);

  sync_bus #(
    .WIDTH  (N_GATES),
    .STAGES (SYNC_STAGES)
  ) u_sync_y (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (GateY),
    .q     (sync_y)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: if (Run) state_d = ST_SET;
      ST_SET:    state_d = mode_valid(mode_in) ? ST_DRIVE : ST_DONE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (vec_q == 2'd3) ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (DISP_RSLT) state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    mode_d       = mode_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    gate_a_d     = gate_a_q;
    gate_b_d     = gate_b_q;
    rslt_d       = rslt_q;
    fail_mask_d  = fail_mask_q;
    fail_vec_d   = fail_vec_q;
    first_fail_d = first_fail_q;
    exp_y        = {N_GATES{gate_expect(mode_q, vec_q[1], vec_q[0])}};
    mism         = '0;

    case (state_q)
      ST_SET: begin
        mode_d       = mode_in;
        vec_d        = 2'd0;
        first_fail_d = 1'b0;
        fail_vec_d   = 2'd0;
        if (mode_valid(mode_in)) begin
          rslt_d      = 1'b1;
          fail_mask_d = '0;
        end else begin
          rslt_d      = 1'b0;
          fail_mask_d = '1;
        end
      end
      ST_DRIVE: begin
        gate_a_d = {N_GATES{vec_q[1]}};
        gate_b_d = {N_GATES{vec_q[0]}};
        cnt_d    = CNT_LOAD;
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      ST_SAMPLE: begin
        mism        = sync_y ^ exp_y;
        fail_mask_d = fail_mask_q | mism;
        if ((mism != '0) && !first_fail_q) begin
          fail_vec_d   = vec_q;
          rslt_d       = 1'b0;
          first_fail_d = 1'b1;
        end
        if (vec_q != 2'd3) vec_d = vec_q + 2'd1;
      end
      default: ;
    endcase

    // Socket inputs are released whenever the tester is not mid-vector.
    if ((state_d == ST_HALTED) || (state_d == ST_SET) || (state_d == ST_DONE)) begin
      gate_a_d = '0;
      gate_b_d = '0;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q       <= MODE_NAND;
      vec_q        <= 2'd0;
      cnt_q        <= '0;
      gate_a_q     <= '0;
      gate_b_q     <= '0;
      done_q       <= 1'b0;
      rslt_q       <= 1'b0;
      fail_mask_q  <= '0;
      fail_vec_q   <= 2'd0;
      first_fail_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      gate_a_q     <= gate_a_d;
      gate_b_q     <= gate_b_d;
      done_q       <= done_d;
      rslt_q       <= rslt_d;
      fail_mask_q  <= fail_mask_d;
      fail_vec_q   <= fail_vec_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign GateA    = gate_a_q;
  assign GateB    = gate_b_q;
  assign Done     = done_q;
  assign RSLT     = rslt_q;
  assign FailMask = fail_mask_q;
  assign FailVec  = fail_vec_q;

endmodule

`default_nettype wire
